mdio_phy_slave: RTL and testbench
=================================

// Module: mdio_phy_slave
// PURPOSE
// Clause-22 MDIO management target (PHY side) that sits directly downstream of the MDIO
// transaction generator. It consumes MDC/MDIO_OUT/MDIO_OE, decodes 32-bit frames
// (ST,OP,PHYAD,REGAD,TA,DATA; no preamble required) against an internal 32x16 register
// file, and answers reads on MDIO_IN. It serves as the bench partner for the generator
// and as the management target in loopback builds.
// PARAMETERS
// PHY_ADDR   5'd2      PHYAD this target answers to; other addresses are ignored
// PHY_ID_HI  16'h0022  reset value of register 2 (read-only)
// PHY_ID_LO  16'h1622  reset value of register 3 (read-only)
// PORTS
// CLK        in   1   system clock; MDC is sampled on it, not used as a clock
// RESET      in   1   asynchronous, active-low reset
// MDC        in   1   management clock from generator; high and low each >=2 CLK periods
// MDIO_OUT   in   1   serial data from generator, MSB first
// MDIO_OE    in   1   generator drive enable; MDIO_OUT is valid only when 1
// MDIO_IN    out  1   serial data to generator; 1 (pull-up) when not driving
// WR_STROBE  out  1   1-CLK pulse when a write frame commits
// WR_ADDR    out  5   REGAD of the last committed write
// WR_DATA    out  16  data of the last committed write
// RD_STROBE  out  1   1-CLK pulse when a read frame finishes its last data bit
// BUSY       out  1   1 whenever FSM != IDLE
// FRAME_ERR  out  1   1-CLK pulse on a malformed frame
// BEHAVIOUR
// - Reset: MDIO_IN=1; WR_STROBE, RD_STROBE, BUSY, FRAME_ERR=0; WR_ADDR=0; WR_DATA=0;
//   FSM=IDLE; bit counter=0; regs 2/3 = PHY_ID_HI/LO; all other regs=0.
// - Edge detect: MDC_q<=MDC each CLK; rise=MDC&~MDC_q; fall=~MDC&MDC_q.
//   All sampling happens in the CLK cycle where rise=1.
// - FSM: IDLE->ST->OP->PHYAD->REGAD->TA->(WDATA|RDATA)->IDLE. A 5-bit counter tracks
//   bits within a field.
// - IDLE: on rise with MDIO_OE=1 and MDIO_OUT=0, go to ST (first start bit consumed).
//   Ones are idle/preamble and are ignored.
// - ST: second bit must be 1; otherwise FRAME_ERR and return to IDLE.
// - OP: 2 bits. 01=write, 10=read; 00 or 11 -> FRAME_ERR, IDLE.
// - PHYAD and REGAD: 5 bits each, MSB first. A PHYAD mismatch does not error: the FSM
//   still tracks the frame to its end, but no strobe, register change or MDIO_IN drive.
// - MDIO_OE=0 on any rise in ST/OP/PHYAD/REGAD -> FRAME_ERR, IDLE.
// - Write TA: 2 bits sampled and ignored (not checked). Then WDATA: 16 bits.
//   On the CLK after the 16th rise: reg[REGAD]<=data, WR_ADDR/WR_DATA updated,
//   WR_STROBE=1 for 1 CLK, back to IDLE.
//   Writes to regs 2/3 pulse WR_STROBE but leave the register unchanged.
// - Read TA: the generator releases OE; its MDIO_OUT is not checked. On the fall after
//   the first TA rise, the slave drives MDIO_IN=0 (TA bit 2).
//   On each subsequent fall, it drives data bits 15..0 of the register value latched at
//   the end of REGAD. MDIO_IN changes 1 CLK after the fall, so it is stable at the next rise.
//   After the 16th data rise: RD_STROBE=1 for 1 CLK, MDIO_IN=1, IDLE.
// - A write and a read in the same cycle cannot occur: there is a single frame at a time.
//   Back-to-back frames need no gap: IDLE accepts a start bit on the very next rise.
// - Reset mid-frame: immediate return to reset values. A partial write never commits.
// - Registers are 16-bit; no arithmetic. The counter wraps only via explicit clear
//   at each field boundary.
// TESTING
// - Write PHY 2, reg 4, data 16'h5F1F -> WR_STROBE 1 CLK, WR_ADDR=4, WR_DATA=16'h5F1F.
//   Then read reg 4 -> MDIO_IN = 0 followed by 0101111100011111, RD_STROBE pulses.
// - Read reg 2 after reset -> MDIO_IN serialises 16'h0022. Write to reg 2, then read
//   again -> still 16'h0022.
// - Frame with PHYAD=5'd7 (write or read) -> no WR/RD_STROBE, MDIO_IN held 1,
//   BUSY returns 0 after 32 MDC rises.
// - OP=2'b11 -> FRAME_ERR pulse at the 4th rise; the next valid frame decodes correctly.
// - Assert RESET=0 midway through WDATA of a write to reg 5 -> reg 5 reads back 0;
//   all outputs are at reset values.
// - Two write frames (reg 1 = 16'hAAAA, reg 1 = 16'h5555) with zero idle bits between
//   them -> two WR_STROBE pulses; reg 1 reads 16'h5555.

Source files
------------

// File: rtl/mdio_phy_slave.sv
// Clause-22 MDIO management target: decodes frames sampled on MDC rises against a
// 32x16 register file and answers reads on MDIO_IN, all clocked from CLK.
module mdio_phy_slave #(
    parameter logic [4:0]  PHY_ADDR  = 5'd2,
    parameter logic [15:0] PHY_ID_HI = 16'h0022,
    parameter logic [15:0] PHY_ID_LO = 16'h1622
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDC,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        WR_STROBE,
    output logic [4:0]  WR_ADDR,
    output logic [15:0] WR_DATA,
    output logic        RD_STROBE,
    output logic        BUSY,
    output logic        FRAME_ERR,
    output logic [2:0]  dbg_state
);

    // Handshake: MDIO_OE is the valid qualifier for MDIO_OUT at each MDC rise; there is
    // no back-pressure, so no ready exists. WR_STROBE qualifies WR_ADDR/WR_DATA for 1 CLK.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ST    = 3'd1;
    localparam logic [2:0] S_OP    = 3'd2;
    localparam logic [2:0] S_PHYAD = 3'd3;
    localparam logic [2:0] S_REGAD = 3'd4;
    localparam logic [2:0] S_TA    = 3'd5;
    localparam logic [2:0] S_WDATA = 3'd6;
    localparam logic [2:0] S_RDATA = 3'd7;

    logic        mdc_q;
    logic        rise;
    logic        fall;
    logic [2:0]  state;
    logic [4:0]  cnt;
    logic        op_hi;
    logic        is_read;
    logic        phy_hit;
    logic [3:0]  field_sr;
    logic [4:0]  field_next;
    logic [4:0]  regad;
    logic [14:0] wd_sr;
    logic [15:0] wd_next;
    logic [15:0] rd_sr;
    logic [15:0] regs [32];

    assign rise       = MDC & ~mdc_q;
    assign fall       = ~MDC & mdc_q;
    assign field_next = {field_sr, MDIO_OUT};
    assign wd_next    = {wd_sr, MDIO_OUT};
    assign BUSY       = (state != S_IDLE);
    assign dbg_state  = state;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mdc_q     <= 1'b0;
            state     <= S_IDLE;
            cnt       <= 5'd0;
            op_hi     <= 1'b0;
            is_read   <= 1'b0;
            phy_hit   <= 1'b0;
            field_sr  <= 4'd0;
            regad     <= 5'd0;
            wd_sr     <= 15'd0;
            rd_sr     <= 16'd0;
            MDIO_IN   <= 1'b1;
            WR_STROBE <= 1'b0;
            WR_ADDR   <= 5'd0;
            WR_DATA   <= 16'd0;
            RD_STROBE <= 1'b0;
            FRAME_ERR <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 2) ? PHY_ID_HI : ((i == 3) ? PHY_ID_LO : 16'd0);
            end
        end else begin
            mdc_q     <= MDC;
            WR_STROBE <= 1'b0;
            RD_STROBE <= 1'b0;
            FRAME_ERR <= 1'b0;
            if (rise) begin
                case (state)
                    S_IDLE: begin
                        if (MDIO_OE && !MDIO_OUT) begin
                            state <= S_ST;
                            cnt   <= 5'd0;
                        end
                    end
                    S_ST: begin
                        if (!MDIO_OE || !MDIO_OUT) begin
                            FRAME_ERR <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_OP;
                            cnt   <= 5'd0;
                        end
                    end
                    S_OP: begin
                        if (!MDIO_OE) begin
                            FRAME_ERR <= 1'b1;
                            state     <= S_IDLE;
                        end else if (cnt == 5'd0) begin
                            op_hi <= MDIO_OUT;
                            cnt   <= 5'd1;
                        end else if (op_hi != MDIO_OUT) begin
                            // 01 = write, 10 = read; the first bit alone tells them apart.
                            is_read <= op_hi;
                            state   <= S_PHYAD;
                            cnt     <= 5'd0;
                        end else begin
                            FRAME_ERR <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    S_PHYAD: begin
                        if (!MDIO_OE) begin
                            FRAME_ERR <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            field_sr <= field_next[3:0];
                            if (cnt == 5'd4) begin
                                phy_hit <= (field_next == PHY_ADDR);
                                state   <= S_REGAD;
                                cnt     <= 5'd0;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                    S_REGAD: begin
                        if (!MDIO_OE) begin
                            FRAME_ERR <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            field_sr <= field_next[3:0];
                            if (cnt == 5'd4) begin
                                regad <= field_next;
                                rd_sr <= regs[field_next];
                                state <= S_TA;
                                cnt   <= 5'd0;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                    S_TA: begin
                        if (cnt == 5'd1) begin
                            state <= is_read ? S_RDATA : S_WDATA;
                            cnt   <= 5'd0;
                        end else begin
                            cnt <= 5'd1;
                        end
                    end
                    S_WDATA: begin
                        wd_sr <= wd_next[14:0];
                        if (cnt == 5'd15) begin
                            if (phy_hit) begin
                                WR_STROBE <= 1'b1;
                                WR_ADDR   <= regad;
                                WR_DATA   <= wd_next;
                                // ID registers acknowledge the write but keep their value.
                                if (regad != 5'd2 && regad != 5'd3) begin
                                    regs[regad] <= wd_next;
                                end
                            end
                            state <= S_IDLE;
                            cnt   <= 5'd0;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    S_RDATA: begin
                        if (cnt == 5'd15) begin
                            RD_STROBE <= phy_hit;
                            MDIO_IN   <= 1'b1;
                            state     <= S_IDLE;
                            cnt       <= 5'd0;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= 5'd0;
                    end
                endcase
            end else if (fall && phy_hit) begin
                // Drive on falls so the value has settled by the generator's next rise.
                if (state == S_TA && is_read && cnt == 5'd1) begin
                    MDIO_IN <= 1'b0;
                end else if (state == S_RDATA) begin
                    MDIO_IN <= rd_sr[15];
                    rd_sr   <= {rd_sr[14:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_phy_slave.sv
// Bench for mdio_phy_slave: a frame-level model predicts every output each CLK,
// directed frames cover the listed scenarios, then randomized frames follow.
module tb_mdio_phy_slave;

    localparam logic [4:0]  PHY   = 5'd2;
    localparam logic [31:0] OE_WR = 32'hFFFF_FFFF;
    localparam logic [31:0] OE_RD = 32'hFFFC_0000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic        MDIO_IN;
    logic        WR_STROBE;
    logic [4:0]  WR_ADDR;
    logic [15:0] WR_DATA;
    logic        RD_STROBE;
    logic        BUSY;
    logic        FRAME_ERR;
    logic [2:0]  dbg_state;

    mdio_phy_slave dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .MDC       (MDC),
        .MDIO_OUT  (MDIO_OUT),
        .MDIO_OE   (MDIO_OE),
        .MDIO_IN   (MDIO_IN),
        .WR_STROBE (WR_STROBE),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .RD_STROBE (RD_STROBE),
        .BUSY      (BUSY),
        .FRAME_ERR (FRAME_ERR),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    int          checks = 0;
    int          failures = 0;
    int          wr_pulses = 0;
    logic        check_en = 1'b0;
    logic [15:0] model_regs [32];
    logic        exp_mdio_in;
    logic        exp_wr_strobe;
    logic        exp_rd_strobe;
    logic        exp_busy;
    logic        exp_frame_err;
    logic [4:0]  exp_wr_addr;
    logic [15:0] exp_wr_data;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 16'd0;
        model_regs[2] = 16'h0022;
        model_regs[3] = 16'h1622;
        exp_mdio_in   = 1'b1;
        exp_wr_strobe = 1'b0;
        exp_rd_strobe = 1'b0;
        exp_busy      = 1'b0;
        exp_frame_err = 1'b0;
        exp_wr_addr   = 5'd0;
        exp_wr_data   = 16'd0;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET    = 1'b0;
        MDC      = 1'b0;
        MDIO_OE  = 1'b0;
        MDIO_OUT = 1'b1;
        model_reset();
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
    endtask

    function automatic logic [31:0] frame(input logic [1:0] op, input logic [4:0] phy,
                                          input logic [4:0] ra, input logic [15:0] data);
        return {2'b01, op, phy, ra, 2'b10, data};
    endfunction

    // Driver + model: bit 31 goes out first; rise i samples bits[32-i].
    task automatic send_frame(input logic [31:0] bits, input logic [31:0] oe, input int nbits,
                              output logic [15:0] rd_word, output logic ta_bit);
        logic [1:0]  op;
        logic [4:0]  ra;
        logic        is_wr;
        logic        is_rd;
        logic        hit;
        int          err_at;
        int          last;
        logic [15:0] rd_val;
        op     = bits[29:28];
        ra     = bits[22:18];
        hit    = (bits[27:23] == PHY);
        err_at = 0;
        if (!oe[30] || !bits[30]) err_at = 2;
        else if (!oe[29]) err_at = 3;
        else if (!oe[28] || op == 2'b00 || op == 2'b11) err_at = 4;
        else begin
            for (int k = 5; k <= 14; k++) begin
                if (err_at == 0 && !oe[32-k]) err_at = k;
            end
        end
        is_wr   = (err_at == 0) && (op == 2'b01);
        is_rd   = (err_at == 0) && (op == 2'b10);
        rd_val  = model_regs[ra];
        last    = (err_at != 0) ? err_at : 32;
        if (nbits < last) last = nbits;
        rd_word = 16'd0;
        ta_bit  = 1'b1;
        if (is_rd && hit && last == 32) exp_q.push_back(rd_val);
        for (int i = 1; i <= last; i++) begin
            @(negedge CLK);
            MDC      = 1'b0;
            MDIO_OE  = oe[32-i];
            MDIO_OUT = bits[32-i];
            if (is_rd && hit && i >= 16) exp_mdio_in = (i == 16) ? 1'b0 : rd_val[32-i];
            repeat (2) @(negedge CLK);
            @(negedge CLK);
            if (i == 16) ta_bit = MDIO_IN;
            if (i >= 17) rd_word[32-i] = MDIO_IN;
            MDC = 1'b1;
            if (i == 1) exp_busy = 1'b1;
            if (i == err_at) begin
                exp_busy      = 1'b0;
                exp_frame_err = 1'b1;
            end
            if (i == 32) begin
                exp_busy = 1'b0;
                if (is_wr && hit) begin
                    exp_wr_strobe = 1'b1;
                    exp_wr_addr   = ra;
                    exp_wr_data   = bits[15:0];
                    if (ra != 5'd2 && ra != 5'd3) model_regs[ra] = bits[15:0];
                end
                if (is_rd && hit) begin
                    exp_rd_strobe = 1'b1;
                    exp_mdio_in   = 1'b1;
                end
            end
            @(negedge CLK);
            exp_wr_strobe = 1'b0;
            exp_rd_strobe = 1'b0;
            exp_frame_err = 1'b0;
            @(negedge CLK);
        end
        if (is_rd && hit && last == 32) check("rd_word", 32'(rd_word), 32'(exp_q.pop_front()));
    endtask

    // scoreboard compare: every CLK, away from the active edge
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (check_en) begin
                check("mdio_in",   32'(MDIO_IN),   32'(exp_mdio_in));
                check("wr_strobe", 32'(WR_STROBE), 32'(exp_wr_strobe));
                check("rd_strobe", 32'(RD_STROBE), 32'(exp_rd_strobe));
                check("busy",      32'(BUSY),      32'(exp_busy));
                check("frame_err", 32'(FRAME_ERR), 32'(exp_frame_err));
                check("wr_addr",   32'(WR_ADDR),   32'(exp_wr_addr));
                check("wr_data",   32'(WR_DATA),   32'(exp_wr_data));
                check("dbg_idle",  32'(dbg_state == 3'd0), 32'(!exp_busy));
                if (WR_STROBE === 1'b1) wr_pulses++;
            end
        end
    end

    // stimulus
    initial begin
        logic [15:0] w;
        logic        t;
        int          p0;
        MDC      = 1'b0;
        MDIO_OE  = 1'b0;
        MDIO_OUT = 1'b1;
        RESET    = 1'b1;
        #1;
        RESET = 1'b0;
        model_reset();
        check_en = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_mdio_in", 32'(MDIO_IN), 32'd1);

        send_frame(frame(2'b01, PHY, 5'd4, 16'h5F1F), OE_WR, 32, w, t);
        check("wr4_addr", 32'(WR_ADDR), 32'd4);
        check("wr4_data", 32'(WR_DATA), 32'h5F1F);
        check("wr4_pulses", 32'(wr_pulses), 32'd1);
        send_frame(frame(2'b10, PHY, 5'd4, 16'h0000), OE_RD, 32, w, t);
        check("rd4_ta", 32'(t), 32'd0);
        check("rd4_word", 32'(w), 32'h5F1F);

        send_frame(frame(2'b10, PHY, 5'd2, 16'h0000), OE_RD, 32, w, t);
        check("rd2_word", 32'(w), 32'h0022);
        send_frame(frame(2'b10, PHY, 5'd3, 16'h0000), OE_RD, 32, w, t);
        check("rd3_word", 32'(w), 32'h1622);
        send_frame(frame(2'b01, PHY, 5'd2, 16'hFFFF), OE_WR, 32, w, t);
        check("wr2_pulses", 32'(wr_pulses), 32'd2);
        send_frame(frame(2'b10, PHY, 5'd2, 16'h0000), OE_RD, 32, w, t);
        check("rd2_ro_word", 32'(w), 32'h0022);

        p0 = wr_pulses;
        send_frame(frame(2'b01, 5'd7, 5'd6, 16'h1234), OE_WR, 32, w, t);
        send_frame(frame(2'b10, 5'd7, 5'd4, 16'h0000), OE_RD, 32, w, t);
        check("phy7_busy", 32'(BUSY), 32'd0);
        check("phy7_pulses", 32'(wr_pulses - p0), 32'd0);
        check("phy7_mdio", 32'({w, t}), 32'h1FFFF);

        send_frame(frame(2'b11, PHY, 5'd8, 16'h0000), OE_WR, 32, w, t);
        send_frame(frame(2'b01, PHY, 5'd8, 16'hABCD), OE_WR, 32, w, t);
        send_frame(frame(2'b10, PHY, 5'd8, 16'h0000), OE_RD, 32, w, t);
        check("rd8_after_err", 32'(w), 32'hABCD);

        send_frame(frame(2'b01, PHY, 5'd5, 16'hC3C3), OE_WR, 24, w, t);
        apply_reset();
        check("midrst_addr", 32'(WR_ADDR), 32'd0);
        check("midrst_data", 32'(WR_DATA), 32'd0);
        send_frame(frame(2'b10, PHY, 5'd5, 16'h0000), OE_RD, 32, w, t);
        check("rd5_after_rst", 32'(w), 32'h0000);

        p0 = wr_pulses;
        send_frame(frame(2'b01, PHY, 5'd1, 16'hAAAA), OE_WR, 32, w, t);
        send_frame(frame(2'b01, PHY, 5'd1, 16'h5555), OE_WR, 32, w, t);
        check("b2b_pulses", 32'(wr_pulses - p0), 32'd2);
        send_frame(frame(2'b10, PHY, 5'd1, 16'h0000), OE_RD, 32, w, t);
        check("rd1_word", 32'(w), 32'h5555);

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [4:0]  phy;
            logic [31:0] b;
            logic [31:0] oe;
            case ($urandom_range(0, 9))
                0:          op = 2'b00;
                1:          op = 2'b11;
                2, 3, 4, 5: op = 2'b01;
                default:    op = 2'b10;
            endcase
            phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : PHY;
            b   = frame(op, phy, 5'($urandom_range(0, 7)), 16'($urandom));
            oe  = (op == 2'b10) ? OE_RD : OE_WR;
            if ($urandom_range(0, 9) == 0) oe[$urandom_range(18, 30)] = 1'b0;
            if ($urandom_range(0, 19) == 0) b[30] = 1'b0;
            send_frame(b, oe, 32, w, t);
        end

        repeat (4) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
